// File: rtl/dense_layer_engine.sv
// Time-multiplexed fully-connected layer: one signed MAC walks N_OUT neurons of N_IN inputs each,
// then applies a per-evaluation activation (saturate, hard-sigmoid or ReLU) to each neuron result.
module dense_layer_engine #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 3,
    parameter int DW    = 8,
    parameter int FRAC  = 7,
    parameter int AW    = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           act_sel,
    input  logic [N_IN*DW-1:0]   x_flat,
    input  logic                 w_we,
    input  logic [AW-1:0]        w_addr,
    input  logic [DW-1:0]        w_data,
    output logic                 busy,
    output logic                 done,
    output logic [N_OUT*DW-1:0]  y_flat
);

    localparam int NW    = N_OUT * (N_IN + 1);
    localparam int PW    = $clog2(NW);
    localparam int IW    = $clog2(N_IN + 1);
    localparam int JW    = $clog2(N_OUT + 1);
    localparam int ACC_W = 2 * DW + $clog2(N_IN + 1) + 1;

    localparam logic signed [ACC_W-1:0] Z_MAX  = ACC_W'((2 ** (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] Z_MIN  = ACC_W'(-(2 ** (DW - 1)));
    localparam logic signed [DW+1:0]    HS_MAX = (DW + 2)'((2 ** FRAC) - 1);
    localparam logic signed [DW+1:0]    HS_OFS = (DW + 2)'(2 ** (FRAC - 1));

    typedef enum logic [1:0] {IDLE, MAC, FINAL, DONE} state_t;

    state_t                     state, state_next;
    logic signed [DW-1:0]       wmem [NW];
    logic [DW-1:0]              y_reg [N_OUT];
    logic [N_IN*DW-1:0]         x_reg, x_shift;
    logic [1:0]                 act_reg;
    logic [IW-1:0]              i_cnt;
    logic [JW-1:0]              j_cnt;
    logic [PW-1:0]              ptr;
    logic signed [ACC_W-1:0]    acc, acc_sh;
    logic signed [DW-1:0]       w_cur, x_cur, bias0, bias_next, z, act_out;
    logic signed [2*DW-1:0]     prod;
    logic signed [DW+1:0]       hs;
    logic                       wr_ok;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = MAC;
            MAC: begin
                busy = 1'b1;
                if (i_cnt == IW'(N_IN - 1)) state_next = FINAL;
            end
            FINAL: begin
                busy       = 1'b1;
                state_next = (j_cnt == JW'(N_OUT - 1)) ? DONE : MAC;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bias for neuron 0 is read on the start edge, so a same-cycle write to it must bypass the file.
    always_comb begin
        wr_ok     = w_we && (state == IDLE) && ({1'b0, w_addr} < (AW + 1)'(NW));
        bias0     = (w_we && (w_addr == AW'(N_IN))) ? w_data : wmem[N_IN];
        bias_next = wmem[ptr + PW'(N_IN + 1)];
        w_cur     = wmem[ptr];
        x_cur     = x_shift[DW-1:0];
        prod      = w_cur * x_cur;
    end

    always_comb begin
        acc_sh = acc >>> FRAC;
        if (acc_sh > Z_MAX)      z = Z_MAX[DW-1:0];
        else if (acc_sh < Z_MIN) z = Z_MIN[DW-1:0];
        else                     z = acc_sh[DW-1:0];
        hs = (DW + 2)'(z >>> 2) + HS_OFS;
        case (act_reg)
            2'd1: begin
                if (hs < 0)           act_out = '0;
                else if (hs > HS_MAX) act_out = HS_MAX[DW-1:0];
                else                  act_out = hs[DW-1:0];
            end
            2'd2:    act_out = (z < 0) ? '0 : z;
            default: act_out = z;
        endcase
    end

    // ptr walks the weight file linearly; after the last MAC of a neuron it rests on that neuron's bias.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc     <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            ptr     <= '0;
            x_reg   <= '0;
            x_shift <= '0;
            act_reg <= '0;
            for (int k = 0; k < NW; k++)    wmem[k]  <= '0;
            for (int k = 0; k < N_OUT; k++) y_reg[k] <= '0;
        end else begin
            if (wr_ok) wmem[w_addr[PW-1:0]] <= w_data;
            case (state)
                IDLE: if (start) begin
                    x_reg   <= x_flat;
                    x_shift <= x_flat;
                    act_reg <= act_sel;
                    i_cnt   <= '0;
                    j_cnt   <= '0;
                    ptr     <= '0;
                    acc     <= (ACC_W'(bias0)) <<< FRAC;
                end
                MAC: begin
                    acc     <= acc + ACC_W'(prod);
                    i_cnt   <= i_cnt + IW'(1);
                    ptr     <= ptr + PW'(1);
                    x_shift <= x_shift >> DW;
                end
                FINAL: begin
                    for (int k = 0; k < N_OUT; k++)
                        if (j_cnt == JW'(k)) y_reg[k] <= act_out;
                    if (j_cnt != JW'(N_OUT - 1)) begin
                        j_cnt   <= j_cnt + JW'(1);
                        i_cnt   <= '0;
                        ptr     <= ptr + PW'(1);
                        x_shift <= x_reg;
                        acc     <= (ACC_W'(bias_next)) <<< FRAC;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_y
        assign y_flat[g*DW +: DW] = y_reg[g];
    end

endmodule
